// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: buffers producer bytes and hands
// them one at a time to the UART through a tx_val/busy start handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     tx_val,
  output logic [WIDTH-1:0]         tx_data,
  input  logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             push_ok;
  logic             pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign tx_data   = tx_data_q;
  assign state_dbg = state_q;

  // Handshake: tx_val is high exactly while in ARM and tx_data is stable there;
  // the UART acknowledges by raising busy, after which tx_val drops. A new byte
  // is only issued once busy has fallen again, so one byte per busy cycle.
  assign tx_val  = (state_q == ARM);
  assign push_ok = wr_en && !full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          pop     = 1'b1;
          state_d = ARM;
        end
      end
      ARM:     if (busy)  state_d = SEND;
      SEND:    if (!busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    tx_data_d = tx_data_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      tx_data_d = mem_q[rd_ptr_q];
    end
    if (push_ok && !pop)      count_d = count_q + ONE_C;
    else if (!push_ok && pop) count_d = count_q - ONE_C;
    // Clear wins over a drop in the same cycle.
    if (ovf_clr)              ovf_d = 1'b0;
    else if (wr_en && full)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage is not reset; a stale entry is never read since count gates pops.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
